// File: rtl/cn_rst_seq.sv
// Reset/BIST sequencer for a chip-level reset interface.
// Order of events: power-good (dcok), a counted reset hold, an optional BIST
// clear/start phase that waits for completion with a timeout, then release of
// rst_n. From DONE a warm-reset request replays the reset hold (and the BIST
// phase if enabled) with dcok kept high.
//
// Handshake: none of the inputs use valid/ready. bist_complete is a level
// sampled on each clk edge while in BIST_RUN only. sw_rst_req is a level
// sampled on each clk edge while in DONE only; it is not remembered from any
// other state.
//
// One down-counter is shared by all timed phases. Each phase loads N-1 on
// entry and exits on the edge where the counter reads zero, so that phase
// lasts exactly N cycles.
module cn_rst_seq #(
  parameter int DCOK_DLY     = 16,
  parameter int RST_HOLD     = 32,
  parameter int BIST_TIMEOUT = 4096,
  parameter int CNT_W        = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic bist_en,
  input  logic sw_rst_req,
  input  logic bist_complete,
  output logic dcok,
  output logic rst_n,
  output logic clear_bist,
  output logic start_bist,
  output logic seq_done,
  output logic bist_fail,
  output logic busy
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_DCOK_WAIT = 3'd1,
    S_RST_HOLD  = 3'd2,
    S_BIST_CLR  = 3'd3,
    S_BIST_RUN  = 3'd4,
    S_RELEASE   = 3'd5,
    S_DONE      = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] DCOK_LD = CNT_W'(DCOK_DLY - 1);
  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(RST_HOLD - 1);
  localparam logic [CNT_W-1:0] TO_LD   = CNT_W'(BIST_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dcok_q, dcok_d;
  logic             rst_n_q, rst_n_d;
  logic             clear_q, clear_d;
  logic             start_q, start_d;
  logic             done_q, done_d;
  logic             fail_q, fail_d;
  logic             busy_q, busy_d;

  // State, counter and every output are registered; reset acts at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dcok_q  <= 1'b0;
      rst_n_q <= 1'b0;
      clear_q <= 1'b0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dcok_q  <= dcok_d;
      rst_n_q <= rst_n_d;
      clear_q <= clear_d;
      start_q <= start_d;
      done_q  <= done_d;
      fail_q  <= fail_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state and next-output logic; everything holds unless a state changes it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dcok_d  = dcok_q;
    rst_n_d = rst_n_q;
    clear_d = clear_q;
    start_d = start_q;
    done_d  = done_q;
    fail_d  = fail_q;
    busy_d  = busy_q;
    case (state_q)
      S_IDLE: begin
        cnt_d   = DCOK_LD;
        state_d = S_DCOK_WAIT;
      end
      S_DCOK_WAIT: begin
        if (cnt_q == '0) begin
          dcok_d  = 1'b1;
          cnt_d   = HOLD_LD;
          state_d = S_RST_HOLD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RST_HOLD: begin
        rst_n_d = 1'b0;
        if (cnt_q == '0) begin
          if (bist_en) begin
            clear_d = 1'b1;
            state_d = S_BIST_CLR;
          end else begin
            rst_n_d = 1'b1;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_DONE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_BIST_CLR: begin
        clear_d = 1'b0;
        start_d = 1'b1;
        cnt_d   = TO_LD;
        state_d = S_BIST_RUN;
      end
      S_BIST_RUN: begin
        // Completion is checked first so it wins over a same-cycle timeout.
        if (bist_complete) begin
          start_d = 1'b0;
          state_d = S_RELEASE;
        end else if (cnt_q == '0) begin
          start_d = 1'b0;
          fail_d  = 1'b1;
          state_d = S_RELEASE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RELEASE: begin
        rst_n_d = 1'b1;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (sw_rst_req) begin
          rst_n_d = 1'b0;
          done_d  = 1'b0;
          fail_d  = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = HOLD_LD;
          state_d = S_RST_HOLD;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign dcok       = dcok_q;
  assign rst_n      = rst_n_q;
  assign clear_bist = clear_q;
  assign start_bist = start_q;
  assign seq_done   = done_q;
  assign bist_fail  = fail_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_cn_rst_seq.sv
// Bench for cn_rst_seq. Each sequence (cold boot or warm request) is described
// by a handful of event times derived from the phase lengths; after every clk
// edge all seven outputs are compared with what those times predict. Ignored
// inputs are driven with random noise wherever the sequencer must not react.
module tb_cn_rst_seq;

  localparam int D = 4;
  localparam int R = 8;
  localparam int T = 20;

  logic clk;
  logic rst;
  logic bist_en;
  logic sw_rst_req;
  logic bist_complete;
  logic dcok;
  logic rst_n;
  logic clear_bist;
  logic start_bist;
  logic seq_done;
  logic bist_fail;
  logic busy;

  int total;
  int bad;

  cn_rst_seq #(
    .DCOK_DLY    (D),
    .RST_HOLD    (R),
    .BIST_TIMEOUT(T),
    .CNT_W       (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bist_en      (bist_en),
    .sw_rst_req   (sw_rst_req),
    .bist_complete(bist_complete),
    .dcok         (dcok),
    .rst_n        (rst_n),
    .clear_bist   (clear_bist),
    .start_bist   (start_bist),
    .seq_done     (seq_done),
    .bist_fail    (bist_fail),
    .busy         (busy)
  );

  // Clock and watchdog.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got=running exp=finished");
    $fatal(1);
  end

  task automatic chk(input string tag, input int e, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at edge %0d: got=%b exp=%b", tag, e, got, exp);
    end
  endtask

  // Run one sequence. warm=0: async reset then cold boot; warm=1: request from DONE.
  // c: bist_complete is driven high from c cycles after start_bist rises.
  // abort_at: stop after checking this edge index (-1 for a full run).
  task automatic run_seq(input bit warm, input bit ben, input int c, input int abort_at);
    int  hold_end;
    int  s;
    int  f;
    int  fin;
    bit  tmo;
    logic ex_dcok, ex_done, ex_clr, ex_start, ex_fail;
    hold_end = (warm ? 0 : D) + R;
    s = hold_end + 1;
    if (c + 1 <= T) begin
      f   = s + c + 1;
      tmo = 1'b0;
    end else begin
      f   = s + T;
      tmo = 1'b1;
    end
    fin = ben ? f + 1 : hold_end;
    bist_en = ben;
    if (!warm) begin
      rst = 1'b1;
      sw_rst_req = 1'b0;
      #1;
      chk("rst_dcok",  -1, dcok,       1'b0);
      chk("rst_rst_n", -1, rst_n,      1'b0);
      chk("rst_clear", -1, clear_bist, 1'b0);
      chk("rst_start", -1, start_bist, 1'b0);
      chk("rst_done",  -1, seq_done,   1'b0);
      chk("rst_fail",  -1, bist_fail,  1'b0);
      chk("rst_busy",  -1, busy,       1'b1);
      bist_complete = 1'($urandom_range(0, 1));
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
    end else begin
      sw_rst_req = 1'b1;
    end
    for (int e = 0; e <= fin + 3; e++) begin
      @(posedge clk);
      #1;
      ex_dcok  = warm ? 1'b1 : (e >= D);
      ex_done  = (e >= fin);
      ex_clr   = ben && (e == hold_end);
      ex_start = ben && (e >= s) && (e < f);
      ex_fail  = ben && tmo && (e >= f);
      chk("dcok",       e, dcok,       ex_dcok);
      chk("rst_n",      e, rst_n,      ex_done);
      chk("seq_done",   e, seq_done,   ex_done);
      chk("busy",       e, busy,       !ex_done);
      chk("clear_bist", e, clear_bist, ex_clr);
      chk("start_bist", e, start_bist, ex_start);
      chk("bist_fail",  e, bist_fail,  ex_fail);
      if (e == abort_at) return;
      if (ben && (e + 1 >= s + 1) && (e + 1 <= f))
        bist_complete = (e + 1 >= s + c + 1);
      else
        bist_complete = 1'($urandom_range(0, 1));
      sw_rst_req = (e < fin) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    sw_rst_req = 1'b0;
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    bist_en = 1'b0;
    sw_rst_req = 1'b0;
    bist_complete = 1'b0;
    repeat (2) @(posedge clk);

    run_seq(1'b0, 1'b0, 0, -1);           // cold boot without BIST
    run_seq(1'b0, 1'b1, 10, -1);          // BIST completes, start high 11 cycles
    run_seq(1'b0, 1'b1, T + 5, -1);       // BIST timeout
    run_seq(1'b1, 1'b1, 5, -1);           // warm reset clears bist_fail
    run_seq(1'b0, 1'b1, T - 1, -1);       // completion on the timeout cycle
    run_seq(1'b1, 1'b0, 0, -1);           // warm reset, no BIST
    run_seq(1'b1, 1'b1, 3, -1);           // warm reset reruns BIST
    run_seq(1'b0, 1'b1, T + 5, D + R + 6); // abort mid BIST_RUN
    run_seq(1'b0, 1'b1, 2, -1);           // async reset checked, full cold restart

    for (int i = 0; i < 14; i++) begin
      run_seq(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, T + 3)), -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cn_rst_seq.md
Name: cn_rst_seq

Overview:
- Power-on and warm-reset sequencer for a chip-level reset/BIST interface.
- Drives dcok, rst_n, clear_bist and start_bist in a fixed, counted order, and waits for bist_complete with a timeout.
- Releases rst_n and reports completion and BIST failure status.
- Sits in the testbench or SoC reset domain, between the power/clock source and the DUT's reset interface.

Parameters:
- DCOK_DLY, 16: cycles from reset deassertion to dcok assertion (>=1).
- RST_HOLD, 32: cycles rst_n is held low after dcok rises, or after a warm request (>=1).
- BIST_TIMEOUT, 4096: maximum cycles start_bist is held waiting for bist_complete (>=1).
- CNT_W, 16: shared down-counter width; must hold max(DCOK_DLY, RST_HOLD, BIST_TIMEOUT).

Ports:
- clk, input, 1: sequencer clock.
- rst, input, 1: asynchronous active-high reset.
- bist_en, input, 1: when 1, the BIST phase runs. Sampled on exit from RST_HOLD.
- sw_rst_req, input, 1: warm-reset request pulse. Honoured only in DONE.
- bist_complete, input, 1: BIST done indication from the DUT.
- dcok, output, 1: power-good to the DUT.
- rst_n, output, 1: active-low reset to the DUT.
- clear_bist, output, 1: one-cycle BIST clear pulse.
- start_bist, output, 1: level BIST start, held until complete or timeout.
- seq_done, output, 1: sequence complete, DUT out of reset.
- bist_fail, output, 1: sticky; BIST timed out.
- busy, output, 1: 1 in every state except DONE.

Behaviour:
- All outputs are registered.
- Async rst: state=IDLE, counter=0, dcok=0, rst_n=0, clear_bist=0, start_bist=0, seq_done=0, bist_fail=0, busy=1. Takes effect immediately, including mid-sequence.
- t0 = first rising clk edge with rst low.
- IDLE:
  - At t0, load counter=DCOK_DLY-1 and go to DCOK_WAIT.
- DCOK_WAIT:
  - Decrement the counter each cycle.
  - At counter==0: dcok<=1, load RST_HOLD-1, go to RST_HOLD.
  - dcok is first observed high after edge t0+DCOK_DLY.
- RST_HOLD:
  - rst_n=0; decrement the counter.
  - At counter==0: if bist_en, clear_bist<=1 and go to BIST_CLR. Else rst_n<=1, seq_done<=1, go to DONE.
  - rst_n stays low exactly RST_HOLD cycles with dcok high.
- BIST_CLR:
  - Lasts exactly 1 cycle: clear_bist<=0, start_bist<=1, load BIST_TIMEOUT-1, go to BIST_RUN.
- BIST_RUN:
  - start_bist=1; decrement the counter.
  - bist_complete sampled 1: start_bist<=0, go to RELEASE.
  - Else at counter==0 (timeout): start_bist<=0, bist_fail<=1, go to RELEASE.
  - bist_complete and timeout in the same cycle: complete wins, bist_fail stays 0.
- RELEASE:
  - Lasts 1 cycle: rst_n<=1, seq_done<=1, go to DONE.
  - rst_n rises one cycle after start_bist falls. The DUT comes out of reset even if BIST failed.
- DONE:
  - busy=0.
  - sw_rst_req=1: rst_n<=0, seq_done<=0, bist_fail<=0, load RST_HOLD-1, go to RST_HOLD.
  - dcok remains 1 on a warm reset.
- Ignored inputs:
  - bist_complete is ignored outside BIST_RUN.
  - sw_rst_req is ignored in every state except DONE. It is not queued.
- Invariants:
  - clear_bist and start_bist are never high together.
  - start_bist is never high while dcok=0.
  - seq_done==1 implies rst_n==1.

Test Plan:
1. Cold boot, bist_en=0, DCOK_DLY=4, RST_HOLD=8. Release rst at edge 0 -> dcok rises after edge 4, rst_n rises after edge 12, seq_done=1 and busy=0 after edge 12, clear_bist/start_bist never assert.
2. Cold boot, bist_en=1, bist_complete driven high 10 cycles after start_bist rises -> clear_bist high exactly 1 cycle, start_bist high 11 cycles, rst_n rises 1 cycle after start_bist falls, bist_fail=0.
3. bist_en=1, BIST_TIMEOUT=20, bist_complete held 0 -> start_bist high exactly 20 cycles, bist_fail=1, rst_n and seq_done rise next cycle. Then sw_rst_req -> bist_fail clears.
4. bist_complete asserted on exactly the timeout cycle -> start_bist drops, bist_fail=0. Also: bist_complete pulsed during RST_HOLD -> no effect.
5. Warm reset from DONE -> rst_n low exactly RST_HOLD cycles, dcok stays 1, BIST reruns if bist_en=1. sw_rst_req pulsed during BIST_RUN -> ignored, no second sequence.
6. Assert rst mid-BIST_RUN -> dcok, rst_n, start_bist and seq_done go 0 asynchronously without waiting for a clk edge. Deassert rst -> full cold sequence restarts from DCOK_WAIT.
